mic_i2s_capture: RTL



---
 rtl/mic_i2s_capture_if.sv | 21 ++
 rtl/mic_i2s_capture.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/mic_i2s_capture_if.sv
// rtl/mic_i2s_capture_if.sv - I2S pins and DMA readout signals of mic_i2s_capture
interface mic_i2s_capture_if;
   logic        enable;
   logic [1:0]  i2s_sd;
   logic        i2s_bclk;
   logic        i2s_ws;
   logic [1:0]  select;
   logic [31:0] mic_data;
   logic        read_ready;
   logic [15:0] overrun_count;

   modport slave (
      input  enable, i2s_sd, select,
      output i2s_bclk, i2s_ws, mic_data, read_ready, overrun_count
   );

   modport master (
      output enable, i2s_sd, select,
      input  i2s_bclk, i2s_ws, mic_data, read_ready, overrun_count
   );
endinterface

// File: rtl/mic_i2s_capture.sv
// rtl/mic_i2s_capture.sv - four-channel I2S mic capture with DMA holding bank
module mic_i2s_capture #(
   parameter int CLK_DIV = 8
) (
   input  logic             CLK,
   input  logic             RESET,
   mic_i2s_capture_if.slave bus
);
   localparam int DW = $clog2(CLK_DIV);

   logic [DW-1:0]    div_q, div_d;
   logic             bclk_q, bclk_d;
   logic             ws_q, ws_d;
   logic [5:0]       bit_idx_q, bit_idx_d;
   logic [1:0]       rise_q, rise_d;
   logic [1:0]       sd_s1_q, sd_s2_q;
   logic [3:0][23:0] sh_q, sh_d;
   logic [3:0][31:0] hold_q, hold_d;
   logic             rr_q, rr_d;
   logic             lock_q, lock_d;
   logic [15:0]      ovr_q, ovr_d;
   logic [1:0]       prev_sel_q;

   logic tc, fall, sample, left_slot, right_slot, frame_done;
   logic lock_set, lock_clr;

   // rise_q delays the BCLK rising edge by two CLKs to pick the sample point
   always_comb begin
      tc         = (div_q == DW'(CLK_DIV - 1));
      div_d      = tc ? '0 : div_q + DW'(1);
      bclk_d     = bclk_q ^ tc;
      fall       = tc && bclk_q;
      bit_idx_d  = fall ? bit_idx_q + 6'd1 : bit_idx_q;
      ws_d       = fall ? bit_idx_d[5] : ws_q;
      rise_d     = {rise_q[0], tc && !bclk_q};
      sample     = rise_q[1] && bus.enable;
      left_slot  = (bit_idx_q >= 6'd1)  && (bit_idx_q <= 6'd24);
      right_slot = (bit_idx_q >= 6'd33) && (bit_idx_q <= 6'd56);
      frame_done = sample && (bit_idx_q == 6'd56);

      sh_d = sh_q;
      if (sample && left_slot) begin
         sh_d[0] = {sh_q[0][22:0], sd_s2_q[0]};
         sh_d[2] = {sh_q[2][22:0], sd_s2_q[1]};
      end
      if (sample && right_slot) begin
         sh_d[1] = {sh_q[1][22:0], sd_s2_q[0]};
         sh_d[3] = {sh_q[3][22:0], sd_s2_q[1]};
      end

      if (!bus.enable) begin
         div_d     = '0;
         bclk_d    = 1'b0;
         ws_d      = 1'b0;
         bit_idx_d = '0;
         rise_d    = '0;
         sh_d      = '0;
      end
   end

   // A lock requested in the same cycle as a frame completion wins over the frame
   always_comb begin
      lock_set = rr_q && (prev_sel_q == 2'd1) && (bus.select == 2'd2);
      lock_clr = (prev_sel_q == 2'd0) && (bus.select != 2'd0);
      lock_d   = lock_q;
      rr_d     = rr_q;
      ovr_d    = ovr_q;
      hold_d   = hold_q;

      if (lock_set) begin
         lock_d = 1'b1;
      end else if (lock_clr) begin
         lock_d = 1'b0;
      end

      if (frame_done) begin
         if (lock_q || lock_set) begin
            if (ovr_q != 16'hFFFF) begin
               ovr_d = ovr_q + 16'd1;
            end
         end else begin
            for (int i = 0; i < 4; i++) begin
               hold_d[i] = {{8{sh_d[i][23]}}, sh_d[i]};
            end
            rr_d = 1'b1;
         end
      end

      if (lock_set) begin
         rr_d = 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         div_q      <= '0;
         bclk_q     <= 1'b0;
         ws_q       <= 1'b0;
         bit_idx_q  <= '0;
         rise_q     <= '0;
         sd_s1_q    <= '0;
         sd_s2_q    <= '0;
         sh_q       <= '0;
         hold_q     <= '0;
         rr_q       <= 1'b0;
         lock_q     <= 1'b0;
         ovr_q      <= '0;
         prev_sel_q <= '0;
      end else begin
         div_q      <= div_d;
         bclk_q     <= bclk_d;
         ws_q       <= ws_d;
         bit_idx_q  <= bit_idx_d;
         rise_q     <= rise_d;
         sd_s1_q    <= bus.i2s_sd;
         sd_s2_q    <= sd_s1_q;
         sh_q       <= sh_d;
         hold_q     <= hold_d;
         rr_q       <= rr_d;
         lock_q     <= lock_d;
         ovr_q      <= ovr_d;
         prev_sel_q <= bus.select;
      end
   end

   // Channel order follows the DMA: select 1..3 -> mics 0..2, select 0 -> mic 3
   always_comb begin
      case (bus.select)
         2'd1:    bus.mic_data = hold_q[0];
         2'd2:    bus.mic_data = hold_q[1];
         2'd3:    bus.mic_data = hold_q[2];
         default: bus.mic_data = hold_q[3];
      endcase
   end

   assign bus.i2s_bclk      = bclk_q;
   assign bus.i2s_ws        = ws_q;
   assign bus.read_ready    = rr_q;
   assign bus.overrun_count = ovr_q;
endmodule
